fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch-side run controller sitting directly downstream of the program counter and upstream of its branch inputs. It presents `pc` to the combinational instruction ROM and decodes the returned word into the `branch`/`imm` pair the PC consumes. It also tracks program run state (run / halted / faulted), signals `done` to the testbench, and keeps retired-instruction, taken-branch and cycle counters for performance reporting.

## Interface
- `IW`, 9: instruction width.
- `PW`, 10: PC / ROM address width.
- `CW`, 16: counter width.
- `ROM_DEPTH`, 1024: number of valid ROM words. A `pc` at or above this value is a fault.
- `MAX_CYC`, 16'hFFFF: watchdog limit on RUN cycles.
- `clk` in 1: single clock. All state updates on its rising edge.
- `start` in 1: reset, synchronous, active-high. Also launches a program.
- `pc` in PW: current PC value from the program counter.
- `imem_data` in IW: ROM word at `imem_addr`, combinational, same cycle.
- `imem_addr` out PW: ROM address, equal to `pc` (pure wire).
- `branch` out 1: branch request to the PC.
- `imm` out 5: branch offset / LUT index to the PC, equal to `imem_data[4:0]`.
- `done` out 1: program finished, level signal.
- `err` out 1: program ended by fault (watchdog or PC range), level signal.
- `instr_cnt` out CW: retired instructions.
- `br_cnt` out CW: branch instructions retired.
- `cycle_cnt` out CW: cycles spent in RUN.

## Operation
- States: `RUN`, `HALT`, `FAULT`. While `start`=1 the next state is `RUN`.
- Decode fields: opcode is `imem_data[8:5]`. Branch opcode `BR_OP` = 4'b1110. Halt word `HALT_W` = 9'h1FF.
- **RUN**
  - `branch` = (opcode == `BR_OP`). Combinational, same cycle as `pc`.
  - Every RUN cycle: `cycle_cnt`+1 and `instr_cnt`+1.
  - `br_cnt`+1 when `branch`=1.
  - `imem_data` == `HALT_W` → go to `HALT`. The halt word is counted in `instr_cnt`.
- **Faults**
  - `pc` >= `ROM_DEPTH` → go to `FAULT`.
  - `cycle_cnt` == `MAX_CYC`-1 while in RUN (the MAX_CYC-th cycle) → go to `FAULT`.
  - A faulting cycle still counts in `cycle_cnt`. It does not count in `instr_cnt` or `br_cnt`.
  - If a halt and a fault occur in the same cycle, `FAULT` wins.
- **HALT**: `done`=1, `err`=0. `branch`=0 regardless of `imem_data`. All counters frozen. The PC keeps incrementing; this is harmless and ignored.
- **FAULT**: `done`=1, `err`=1. Otherwise identical to HALT.
- Both HALT and FAULT hold until `start`.
- **Counters**: saturate at all-ones. They never wrap.
- `imm` is driven in every state and is meaningful only when `branch`=1.

## Timing
- **Reset values**, on the edge where `start`=1: state `RUN`, `done`=0, `err`=0, all counters 0.
- `branch` during a `start`=1 cycle is 0.
- The first cycle after `start` falls executes the word at the PC's reset address.
- `branch` and `imm` have zero latency from `pc` / `imem_data`.
- `done` and `err` are registered. They rise on the edge after the halt or fault cycle.
- Counter values are registered and visible one cycle after the event.
- `start` mid-run, in any state: the next edge applies the reset values. The in-flight instruction is not counted.

## Structure
- `fetch_pkg`:
  - `state_t` enum {RUN, HALT, FAULT}.
  - `BR_OP`, `HALT_W`.
  - Opcode field bounds.
- Sub-module `sat_counter` (CW-bit, synchronous clear, increment enable, saturating), instantiated three times.
- Decode and FSM live in the top file.

## Test plan
- **Straight-line halt.** ROM[0..3]=9'h000, ROM[4]=9'h1FF. Pulse `start` for 2 cycles. Expect:
  - `branch` never high.
  - `done`=1 on the edge after pc=4.
  - `instr_cnt`=5, `cycle_cnt`=5, `br_cnt`=0, `err`=0.
- **Branch decode.** ROM[2]=9'h1C3. Expect `branch`=1 and `imm`=5'b00011 only in the cycle pc=2; `br_cnt`=1 after halt.
- **Mid-run restart.** Raise `start` when `instr_cnt`=7. Expect counters=0, `done`=0, `err`=0, state RUN on that edge.
- **Watchdog.** ROM all 9'h000 plus a self-branch, `MAX_CYC`=32. Expect:
  - `done`=`err`=1 on the edge after the 32nd RUN cycle.
  - `cycle_cnt`=32, `instr_cnt`=31.
- **Halted idle.** In HALT, drive `imem_data`=9'h1C3. Expect `branch`=0 and counters frozen for 10 cycles.
- **PC range.** `ROM_DEPTH`=64, drive `pc`=64. Expect `err`=1 and `done`=1 next edge; the same-cycle halt word at that PC is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: run states and instruction decode constants for fetch_ctrl
package fetch_pkg;
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
  localparam logic [3:0] BR_OP = 4'b1110;
  localparam logic [8:0] HALT_W = 9'h1FF;
  localparam int OP_HI = 8;
  localparam int OP_LO = 5;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-clear increment counter that sticks at all-ones
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] q
);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over increment; increment stops at all-ones
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction decode, run/halt/fault tracking and perf counters
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            IW        = 9,
  parameter int            PW        = 10,
  parameter int            CW        = 16,
  parameter int            ROM_DEPTH = 1024,
  parameter logic [CW-1:0] MAX_CYC   = 16'hFFFF
) (
  input  logic          clk,
  input  logic          start,
  input  logic [PW-1:0] pc,
  input  logic [IW-1:0] imem_data,
  output logic [PW-1:0] imem_addr,
  output logic          branch,
  output logic [4:0]    imm,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] instr_cnt,
  output logic [CW-1:0] br_cnt,
  output logic [CW-1:0] cycle_cnt
);
  state_t state_q, state_d;
  logic done_q, done_d, err_q, err_d;
  logic run, is_br, halt, fault;
  // decode the current word and pick the next run state; fault beats halt
  always_comb begin
    run     = state_q == RUN && !start;
    is_br   = imem_data[OP_HI:OP_LO] == BR_OP;
    halt    = imem_data == IW'(HALT_W);
    fault   = 32'(pc) >= 32'(ROM_DEPTH) || cycle_cnt == MAX_CYC - 1'b1;
    state_d = start ? RUN : !run ? state_q : fault ? FAULT : halt ? HALT : RUN;
    done_d  = state_d != RUN;
    err_d   = state_d == FAULT;
  end
  // state and registered status flags, start acts as synchronous reset
  always_ff @(posedge clk) begin
    if (start) begin
      state_q <= RUN;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign imem_addr = pc;
  assign imm       = imem_data[4:0];
  assign branch    = run && is_br;
  assign done      = done_q;
  assign err       = err_q;
  sat_counter #(.CW(CW)) u_cyc (.clk(clk), .clr(start), .inc(run),           .q(cycle_cnt));
  sat_counter #(.CW(CW)) u_ins (.clk(clk), .clr(start), .inc(run && !fault), .q(instr_cnt));
  sat_counter #(.CW(CW)) u_br  (.clk(clk), .clr(start), .inc(branch && !fault), .q(br_cnt));
endmodule
